// File: rtl/codec_tx_pkg.sv
// Shared types and default geometry for the codec sample transmitter.
package codec_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int SAMPLE_W = 16;
  localparam int SLOT_W   = 16;
  localparam int BCLK_DIV = 4;

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock divider: bclk low for the first half of each period, high for the second.
// fall marks the first clk of a period (bclk falling), last marks its final clk.
module bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bclk,
  output logic fall,
  output logic last
);

  localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

  logic [DW-1:0] div_cnt_q, div_cnt_d;

  // Free-running modulo counter, parked at 0 while stopped so bclk idles low.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!run) div_cnt_d = '0;
    else if (div_cnt_q == DW'(BCLK_DIV - 1)) div_cnt_d = '0;
    else div_cnt_d = div_cnt_q + 1'b1;
  end

  // Divider state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_cnt_q <= '0;
    else div_cnt_q <= div_cnt_d;
  end

  assign bclk = (div_cnt_q >= DW'(BCLK_DIV / 2));
  assign fall = run && (div_cnt_q == '0);
  assign last = run && (div_cnt_q == DW'(BCLK_DIV - 1));

endmodule

// File: rtl/dffre.sv
// Generic enabled register with asynchronous active-low clear.
module dffre #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled, clear on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/codec_sample_tx.sv
// Serial DAC transmitter: requests one mono sample per frame and shifts it
// MSB-first, left-justified, into both the left and right slots.
// Optional build macro UNDERRUN_CNT_EN adds underrun_cnt and sticky underrun outputs.
//
// state | meaning
// IDLE  | stopped, all outputs at reset values
// RUN   | frames repeat back to back
// DRAIN | en dropped, finishing the current frame
module codec_sample_tx #(
  parameter int SAMPLE_W = codec_tx_pkg::SAMPLE_W,
  parameter int SLOT_W   = codec_tx_pkg::SLOT_W,
  parameter int BCLK_DIV = codec_tx_pkg::BCLK_DIV
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                new_sample_ready,
  output logic                sampling_pulse,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
`ifdef UNDERRUN_CNT_EN
  output logic [15:0]         underrun_cnt,
  output logic                underrun,
`endif
  output logic                busy
);

  import codec_tx_pkg::*;

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BW      = $clog2(FRAME_W);

  state_e              state_q, state_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]  shift_q, shift_d;
  logic                req_pend_q, req_pend_d;
  logic [SAMPLE_W-1:0] hold_q;
  logic [SLOT_W-1:0]   word;
  logic                run, fall, last, bclk_raw;
  logic                frame_start, frame_last, capture;

  assign run         = (state_q != IDLE);
  assign frame_start = fall && (bit_cnt_q == '0);
  assign frame_last  = last && (bit_cnt_q == BW'(FRAME_W - 1));
  assign capture     = new_sample_ready && req_pend_q;
  assign word        = SLOT_W'(hold_q) << (SLOT_W - SAMPLE_W);

  bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .bclk  (bclk_raw),
    .fall  (fall),
    .last  (last)
  );

  // Sample hold: only a requested sample is accepted.
  dffre #(.W(SAMPLE_W)) u_hold (
    .clk   (clk),
    .reset (reset),
    .en    (capture),
    .d     (sample),
    .q     (hold_q)
  );

  // Next state, bit counter, shifter and request flag.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    req_pend_d = req_pend_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN:   if (en) state_d = RUN;
               else if (frame_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!run) bit_cnt_d = '0;
    else if (frame_last) bit_cnt_d = '0;
    else if (last) bit_cnt_d = bit_cnt_q + 1'b1;
    // Loading both slots at once gives the right-slot reload for free.
    if (frame_start) shift_d = {word, word};
    else if (fall) shift_d = shift_q << 1;
    // A new request at frame start outranks a same-cycle capture.
    if (frame_start) req_pend_d = 1'b1;
    else if (capture) req_pend_d = 1'b0;
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      req_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      req_pend_q <= req_pend_d;
    end
  end

`ifdef UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;
  logic        underrun_q, underrun_d;
  logic        underrun_evt;

  assign underrun_evt = frame_start && req_pend_q && !new_sample_ready;

  // Saturating underrun counter and sticky flag.
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    underrun_d     = underrun_q;
    if (underrun_evt) begin
      underrun_d = 1'b1;
      if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
  end

  // Underrun statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun_cnt_q <= '0;
      underrun_q     <= 1'b0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
      underrun_q     <= underrun_d;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
  assign underrun     = underrun_q;
`endif

  assign sampling_pulse = frame_start;
  assign bclk           = run && bclk_raw;
  assign lrclk          = run && (bit_cnt_q >= BW'(SLOT_W));
  assign sdata          = run && shift_q[FRAME_W-1];
  assign busy           = run;

endmodule
